// File: rtl/pattern_seq_ctrl_pkg.sv
// Shared constants and the controller state encoding for the pattern sequencer.
package pattern_seq_pkg;

  // Generator phases per pattern period.
  localparam int PATTERN_LEN_DEF = 11;

  // Width of the phase output.
  localparam int PHASE_W = 4;

  // Controller state, also shown on the board LEDs.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/pattern_seq_ctrl_if.sv
// Button, target and status bundle between the board glue and the controller.
interface pattern_seq_ctrl_if
  import pattern_seq_pkg::*;
#(
  parameter int CNT_W = 8
) ();

  logic               btn_start;
  logic               btn_stop;
  logic               btn_step;
  logic [CNT_W-1:0]   cycles_target;
  logic               step_en;
  logic               gen_clr;
  logic [PHASE_W-1:0] phase;
  logic [CNT_W-1:0]   period_cnt;
  logic [1:0]         ctrl_state;
  logic               busy;

  modport master (
    output btn_start, btn_stop, btn_step, cycles_target,
    input  step_en, gen_clr, phase, period_cnt, ctrl_state, busy
  );

  modport slave (
    input  btn_start, btn_stop, btn_step, cycles_target,
    output step_en, gen_clr, phase, period_cnt, ctrl_state, busy
  );

endinterface

// File: rtl/pattern_seq_ctrl_tick_prescaler.sv
// Mod-TICK_DIV counter producing the automatic step request.
// tick is combinational so the controller can register step_en on the same
// edge that wraps the count. hold_at_max freezes the count in any position,
// so a stop landing on the terminal count keeps it there for the resume.
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic hold_at_max,
  output logic tick
);

  localparam int            CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);

  logic [CW-1:0] count_r;

  assign tick = en & ~hold_at_max & (count_r == CNT_LAST);

  // Advance the count while enabled and not frozen, wrapping at the terminal value.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= CNT_ZERO;
    end else if (en && !hold_at_max) begin
      count_r <= (count_r == CNT_LAST) ? CNT_ZERO : (count_r + CNT_ONE);
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/pattern_seq_ctrl.sv
// Run/pause/step controller for the 11-phase x/y pattern generator.
// Button edges drive a 4-state FSM; every output is a flop, so phase and
// step_en change on the same edge and phase leads the generator by a cycle.
module pattern_seq_ctrl
  import pattern_seq_pkg::*;
#(
  parameter int TICK_DIV    = 50_000_000,
  parameter int PATTERN_LEN = PATTERN_LEN_DEF,
  parameter int CNT_W       = 8
) (
  input logic               clk,
  input logic               reset,
  pattern_seq_ctrl_if.slave bus
);

  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(PATTERN_LEN - 1);
  localparam logic [PHASE_W-1:0] PHASE_ONE  = PHASE_W'(1);
  localparam logic [PHASE_W-1:0] PHASE_ZERO = PHASE_W'(0);
  localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ZERO   = CNT_W'(0);

  ctrl_state_e        state_r, state_n_s;
  logic               start_q_r, stop_q_r, step_q_r;
  logic               ev_start_s, ev_stop_s, ev_step_s;
  logic [PHASE_W-1:0] phase_r, phase_n_s;
  logic [CNT_W-1:0]   cnt_r, cnt_n_s;
  logic [CNT_W-1:0]   target_r, target_n_s;
  logic               step_en_r, gen_clr_r, busy_r;
  logic               step_n_s, clr_n_s, do_step_s;
  logic               presc_clr_s, presc_en_s, presc_hold_s, presc_rst_s, tick_s;

  assign ev_start_s = bus.btn_start & ~start_q_r;
  assign ev_stop_s  = bus.btn_stop  & ~stop_q_r;
  assign ev_step_s  = bus.btn_step  & ~step_q_r;

  // A fresh start clears the prescaler alongside the reset.
  assign presc_rst_s = reset | presc_clr_s;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_presc (
    .clk         (clk),
    .reset       (presc_rst_s),
    .en          (presc_en_s),
    .hold_at_max (presc_hold_s),
    .tick        (tick_s)
  );

  // Next state, step request and counter updates; stop beats start beats step.
  always_comb begin
    state_n_s    = state_r;
    phase_n_s    = phase_r;
    cnt_n_s      = cnt_r;
    target_n_s   = target_r;
    clr_n_s      = 1'b0;
    do_step_s    = 1'b0;
    presc_clr_s  = 1'b0;
    presc_en_s   = 1'b0;
    presc_hold_s = 1'b0;

    case (state_r)
      ST_RUN: begin
        presc_en_s = 1'b1;
        if (ev_stop_s) begin
          presc_hold_s = 1'b1;
          state_n_s    = ST_PAUSE;
        end else begin
          do_step_s = tick_s;
        end
      end
      ST_PAUSE: begin
        if (ev_stop_s) begin
          state_n_s = ST_IDLE;
          clr_n_s   = 1'b1;
          phase_n_s = PHASE_ZERO;
          cnt_n_s   = CNT_ZERO;
        end else if (ev_start_s) begin
          state_n_s = ST_RUN;
        end else begin
          do_step_s = ev_step_s;
        end
      end
      ST_IDLE, ST_DONE: begin
        if (ev_stop_s && (state_r == ST_DONE)) begin
          state_n_s = ST_IDLE;
        end else if (ev_start_s) begin
          state_n_s   = ST_RUN;
          clr_n_s     = 1'b1;
          phase_n_s   = PHASE_ZERO;
          cnt_n_s     = CNT_ZERO;
          presc_clr_s = 1'b1;
          target_n_s  = bus.cycles_target;
        end else begin
          state_n_s = state_r;
        end
      end
      default: begin
        state_n_s = ST_IDLE;
      end
    endcase

    step_n_s = do_step_s;
    if (do_step_s) begin
      if (phase_r == PHASE_LAST) begin
        phase_n_s = PHASE_ZERO;
        cnt_n_s   = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);
        state_n_s = ((target_r != CNT_ZERO) && (cnt_n_s == target_r)) ? ST_DONE : state_n_s;
      end else begin
        phase_n_s = phase_r + PHASE_ONE;
      end
    end else begin
      step_n_s = 1'b0;
    end
  end

  // Button history, FSM state and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      start_q_r <= 1'b0;
      stop_q_r  <= 1'b0;
      step_q_r  <= 1'b0;
      state_r   <= ST_IDLE;
      phase_r   <= PHASE_ZERO;
      cnt_r     <= CNT_ZERO;
      target_r  <= CNT_ZERO;
      step_en_r <= 1'b0;
      gen_clr_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      start_q_r <= bus.btn_start;
      stop_q_r  <= bus.btn_stop;
      step_q_r  <= bus.btn_step;
      state_r   <= state_n_s;
      phase_r   <= phase_n_s;
      cnt_r     <= cnt_n_s;
      target_r  <= target_n_s;
      step_en_r <= step_n_s;
      gen_clr_r <= clr_n_s;
      busy_r    <= (state_n_s == ST_RUN) || (state_n_s == ST_PAUSE);
    end
  end

  assign bus.step_en    = step_en_r;
  assign bus.gen_clr    = gen_clr_r;
  assign bus.phase      = phase_r;
  assign bus.period_cnt = cnt_r;
  assign bus.ctrl_state = state_r;
  assign bus.busy       = busy_r;

endmodule

// File: tb/tb_pattern_seq_ctrl.sv
// Self-checking bench for pattern_seq_ctrl with TICK_DIV=4.
module tb_pattern_seq_ctrl;

  localparam int TD   = 4;
  localparam int PL   = 11;
  localparam int CMAX = 255;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  pattern_seq_ctrl_if #(.CNT_W(8)) bus ();

  pattern_seq_ctrl #(
    .TICK_DIV    (TD),
    .PATTERN_LEN (PL),
    .CNT_W       (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_on   = 1'b0;

  // behavioural model state: 0 idle, 1 run, 2 pause, 3 done
  int m_state = 0, m_phase = 0, m_cnt = 0, m_target = 0, m_presc = 0;
  bit m_step = 1'b0, m_clr = 1'b0;
  bit p_start = 1'b0, p_stop = 1'b0, p_step = 1'b0;

  int seen_step = 0, seen_clr = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_advance();
    m_step  = 1'b1;
    m_phase = (m_phase + 1) % PL;
    if (m_phase == 0) begin
      if (m_cnt < CMAX) m_cnt++;
      if (m_target != 0 && m_cnt == m_target) m_state = 3;
    end
  endtask

  // what the controller must do at one clock edge, given the inputs present
  task automatic model_step();
    bit es, ep, et;
    if (reset) begin
      m_state = 0; m_phase = 0; m_cnt = 0; m_target = 0; m_presc = 0;
      m_step = 1'b0; m_clr = 1'b0;
      p_start = 1'b0; p_stop = 1'b0; p_step = 1'b0;
      return;
    end
    es = bus.btn_start && !p_start;
    ep = bus.btn_stop  && !p_stop;
    et = bus.btn_step  && !p_step;
    p_start = bus.btn_start; p_stop = bus.btn_stop; p_step = bus.btn_step;
    m_step = 1'b0; m_clr = 1'b0;
    case (m_state)
      1: begin
        if (ep) m_state = 2;
        else if (m_presc == TD - 1) begin m_presc = 0; model_advance(); end
        else m_presc++;
      end
      2: begin
        if (ep) begin m_state = 0; m_clr = 1'b1; m_phase = 0; m_cnt = 0; end
        else if (es) m_state = 1;
        else if (et) model_advance();
      end
      default: begin
        if (m_state == 3 && ep) m_state = 0;
        else if (es) begin
          m_state = 1; m_clr = 1'b1; m_phase = 0; m_cnt = 0; m_presc = 0;
          m_target = int'(bus.cycles_target);
        end
      end
    endcase
  endtask

  // every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (chk_on) begin
      chk("state", int'(bus.ctrl_state), m_state);
      chk("busy", int'(bus.busy), (m_state == 1 || m_state == 2) ? 1 : 0);
      chk("step_en", int'(bus.step_en), int'(m_step));
      chk("gen_clr", int'(bus.gen_clr), int'(m_clr));
      chk("phase", int'(bus.phase), m_phase);
      chk("period_cnt", int'(bus.period_cnt), m_cnt);
    end
  end

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (bus.step_en) seen_step++;
    if (bus.gen_clr) seen_clr++;
  endtask

  task automatic cycn(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic press(input int which);
    if (which == 0) bus.btn_start = 1'b1;
    else if (which == 1) bus.btn_stop = 1'b1;
    else bus.btn_step = 1'b1;
    cyc();
    bus.btn_start = 1'b0; bus.btn_stop = 1'b0; bus.btn_step = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bit found;
    bus.btn_start = 1'b0; bus.btn_stop = 1'b0; bus.btn_step = 1'b0;
    bus.cycles_target = 8'd2;
    do_reset();
    chk_on = 1'b1;
    chk("rst_state", int'(bus.ctrl_state), 0);
    chk("rst_phase", int'(bus.phase), 0);
    chk("rst_busy", int'(bus.busy), 0);

    // target 2: 22 steps then DONE
    press(0);
    chk("t1_clr", int'(bus.gen_clr), 1);
    chk("t1_run", int'(bus.ctrl_state), 1);
    seen_step = 0;
    cycn(44);
    chk("t1_steps11", seen_step, 11);
    chk("t1_cnt1", int'(bus.period_cnt), 1);
    chk("t1_phase0", int'(bus.phase), 0);
    chk("t1_model_cnt1", m_cnt, 1);
    cycn(44);
    chk("t1_done", int'(bus.ctrl_state), 3);
    chk("t1_done_cnt", int'(bus.period_cnt), 2);
    chk("t1_done_phase", int'(bus.phase), 0);
    seen_step = 0;
    cycn(12);
    chk("t1_no_step", seen_step, 0);

    // target 0: 300 steps
    do_reset();
    bus.cycles_target = 8'd0;
    press(0);
    seen_step = 0;
    cycn(1200);
    chk("t2_steps", seen_step, 300);
    chk("t2_cnt", int'(bus.period_cnt), 27);
    chk("t2_phase", int'(bus.phase), 3);
    chk("t2_run", int'(bus.ctrl_state), 1);

    // pause after two counts, manual steps, resume latency
    do_reset();
    press(0);
    cycn(2);
    seen_step = 0;
    press(1);
    chk("t3_pause", int'(bus.ctrl_state), 2);
    cycn(5);
    chk("t3_no_step", seen_step, 0);
    for (int k = 0; k < 3; k++) begin
      press(2);
      chk("t3_manual_step", int'(bus.step_en), 1);
      cyc();
    end
    chk("t3_steps3", seen_step, 3);
    chk("t3_phase3", int'(bus.phase), 3);
    press(0);
    chk("t3_r0", int'(bus.step_en), 0);
    cyc();
    chk("t3_r1", int'(bus.step_en), 0);
    cyc();
    chk("t3_r2", int'(bus.step_en), 1);
    chk("t3_phase4", int'(bus.phase), 4);

    // stop on terminal count
    cycn(3);
    press(1);
    chk("t4_stop_nostep", int'(bus.step_en), 0);
    chk("t4_pause", int'(bus.ctrl_state), 2);
    cyc();
    press(0);
    chk("t4_r0", int'(bus.step_en), 0);
    cyc();
    chk("t4_r1", int'(bus.step_en), 1);
    chk("t4_phase5", int'(bus.phase), 5);

    // simultaneous buttons in PAUSE, then held start
    press(1);
    cyc();
    bus.btn_start = 1'b1; bus.btn_stop = 1'b1; bus.btn_step = 1'b1;
    cyc();
    bus.btn_start = 1'b0; bus.btn_stop = 1'b0; bus.btn_step = 1'b0;
    chk("t5_idle", int'(bus.ctrl_state), 0);
    chk("t5_clr", int'(bus.gen_clr), 1);
    chk("t5_nostep", int'(bus.step_en), 0);
    cycn(2);
    seen_clr = 0;
    bus.btn_start = 1'b1;
    cycn(20);
    bus.btn_start = 1'b0;
    chk("t5_one_start", seen_clr, 1);
    chk("t5_run", int'(bus.ctrl_state), 1);

    // reset mid-run at phase 7
    do_reset();
    press(0);
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      cyc();
      if (m_cnt == 1 && m_phase == 7) found = 1'b1;
    end
    chk("t6_reach_phase7", int'(found), 1);
    chk("t6_dut_phase7", int'(bus.phase), 7);
    reset = 1'b1;
    cyc();
    chk("t6_idle", int'(bus.ctrl_state), 0);
    chk("t6_phase", int'(bus.phase), 0);
    chk("t6_cnt", int'(bus.period_cnt), 0);
    chk("t6_step", int'(bus.step_en), 0);
    chk("t6_clr", int'(bus.gen_clr), 0);
    reset = 1'b0;
    cycn(3);

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
